// File: rtl/text_buffer_pkg.sv
// Shared constants for the text buffer controller: ASCII control codes,
// printable range, FSM state encoding and default grid geometry.
package text_buffer_pkg;

  localparam int unsigned DEF_COLS = 16;
  localparam int unsigned DEF_ROWS = 12;

  localparam logic [7:0] ASCII_CR       = 8'h0D;
  localparam logic [7:0] ASCII_BS       = 8'h08;
  localparam logic [7:0] ASCII_ESC      = 8'h1B;
  localparam logic [7:0] ASCII_PRINT_LO = 8'h20;
  localparam logic [7:0] ASCII_PRINT_HI = 8'h7E;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_CLEAR
  } tbc_state_t;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= ASCII_PRINT_LO) && (c <= ASCII_PRINT_HI);
  endfunction

endpackage

// File: rtl/tbc_key_fifo.sv
// Small synchronous keystroke FIFO with full/empty flags and occupancy count.
// Head entry is presented combinationally; DEPTH must be a power of 2 (>= 2).
module tbc_key_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/text_buffer_ctrl.sv
// Sequencer/arbiter for the single-port character RAM of the text grid.
// Keystrokes arrive through a FIFO and become RAM writes, cursor moves or a
// full-screen clear; VGA reads always win the RAM port.
// Optional: define TBC_ERASE_ON_BS_EN to make backspace blank the cell it
// moves onto.
module text_buffer_ctrl
  import text_buffer_pkg::*;
#(
  parameter int unsigned COLS       = DEF_COLS,
  parameter int unsigned ROWS       = DEF_ROWS,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  BLANK_CHAR = 8'h20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_valid,
  input  logic [7:0]        key_ascii,
  output logic              key_ready,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_data,
  output logic              ram_wren,
  input  logic [7:0]        ram_q,
  output logic [3:0]        cur_col,
  output logic [3:0]        cur_row,
  output logic              busy,
  output logic [7:0]        drop_cnt
);

  localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [3:0]  LAST_COL  = 4'(COLS - 1);
  localparam logic [3:0]  LAST_ROW  = 4'(ROWS - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);

  tbc_state_t        state, state_nxt;
  logic [3:0]        col, col_nxt, row, row_nxt;
  logic [3:0]        bs_col, bs_row;
  logic [ADDR_W-1:0] wr_addr, wr_addr_nxt, clr_addr, clr_addr_nxt;
  logic [7:0]        wr_data, wr_data_nxt;
  logic              wr_noadv, wr_noadv_nxt;
  logic              busy_q, busy_nxt;
  logic              ready_en;
  logic              fifo_pop, fifo_full, fifo_empty;
  logic [7:0]        fifo_head;
  logic [CW-1:0]     fifo_count;
  logic              drop_evt;

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [3:0] r, input logic [3:0] c);
    return ADDR_W'(r) * ADDR_W'(COLS) + ADDR_W'(c);
  endfunction

  // ready_en holds key_ready low through reset and the first edge after it.
  assign key_ready = ready_en && (fifo_count != CW'(FIFO_DEPTH));
  assign drop_evt  = key_valid && ready_en && fifo_full;
  assign rd_data   = ram_q;
  assign cur_col   = col;
  assign cur_row   = row;
  assign busy      = busy_q;

  tbc_key_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (key_valid && key_ready),
    .push_data (key_ascii),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Backspace target cell: step left, or to the end of the previous row.
  always_comb begin
    bs_col = col;
    bs_row = row;
    if (col != 4'd0) begin
      bs_col = col - 4'd1;
    end else if (row != 4'd0) begin
      bs_row = row - 4'd1;
      bs_col = LAST_COL;
    end
  end

  // Next-state, decode, cursor update and RAM port arbitration.
  always_comb begin
    state_nxt    = state;
    col_nxt      = col;
    row_nxt      = row;
    wr_addr_nxt  = wr_addr;
    wr_data_nxt  = wr_data;
    wr_noadv_nxt = wr_noadv;
    clr_addr_nxt = clr_addr;
    busy_nxt     = busy_q;
    fifo_pop     = 1'b0;
    ram_addr     = '0;
    ram_data     = '0;
    ram_wren     = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (is_printable(fifo_head)) begin
            wr_addr_nxt  = cell_addr(row, col);
            wr_data_nxt  = fifo_head;
            wr_noadv_nxt = 1'b0;
            state_nxt    = ST_WRITE;
          end else if (fifo_head == ASCII_CR) begin
            col_nxt = 4'd0;
            row_nxt = (row == LAST_ROW) ? 4'd0 : row + 4'd1;
          end else if (fifo_head == ASCII_BS) begin
            col_nxt = bs_col;
            row_nxt = bs_row;
`ifdef TBC_ERASE_ON_BS_EN
            wr_addr_nxt  = cell_addr(bs_row, bs_col);
            wr_data_nxt  = BLANK_CHAR;
            wr_noadv_nxt = 1'b1;
            state_nxt    = ST_WRITE;
`endif
          end else if (fifo_head == ASCII_ESC) begin
            clr_addr_nxt = '0;
            busy_nxt     = 1'b1;
            state_nxt    = ST_CLEAR;
          end
        end
      end
      ST_WRITE: begin
        if (!rd_req) begin
          ram_wren  = 1'b1;
          ram_addr  = wr_addr;
          ram_data  = wr_data;
          state_nxt = ST_IDLE;
          if (!wr_noadv) begin
            if (col == LAST_COL) begin
              col_nxt = 4'd0;
              row_nxt = (row == LAST_ROW) ? 4'd0 : row + 4'd1;
            end else begin
              col_nxt = col + 4'd1;
            end
          end
        end
      end
      ST_CLEAR: begin
        if (!rd_req) begin
          ram_wren = 1'b1;
          ram_addr = clr_addr;
          ram_data = BLANK_CHAR;
          if (clr_addr == LAST_ADDR) begin
            col_nxt   = 4'd0;
            row_nxt   = 4'd0;
            busy_nxt  = 1'b0;
            state_nxt = ST_IDLE;
          end else begin
            clr_addr_nxt = clr_addr + ADDR_W'(1);
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (rd_req) ram_addr = rd_addr;

    if (reset) begin
      fifo_pop = 1'b0;
      ram_addr = '0;
      ram_data = '0;
      ram_wren = 1'b0;
    end
  end

  // State, cursor and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      col      <= 4'd0;
      row      <= 4'd0;
      wr_addr  <= '0;
      wr_data  <= '0;
      wr_noadv <= 1'b0;
      clr_addr <= '0;
      busy_q   <= 1'b0;
      ready_en <= 1'b0;
      rd_valid <= 1'b0;
      drop_cnt <= '0;
    end else begin
      state    <= state_nxt;
      col      <= col_nxt;
      row      <= row_nxt;
      wr_addr  <= wr_addr_nxt;
      wr_data  <= wr_data_nxt;
      wr_noadv <= wr_noadv_nxt;
      clr_addr <= clr_addr_nxt;
      busy_q   <= busy_nxt;
      ready_en <= 1'b1;
      rd_valid <= rd_req;
      if (drop_evt && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_text_buffer_ctrl.sv
// Directed self-checking bench for text_buffer_ctrl with a 1-cycle RAM model.
module tb_text_buffer_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [7:0] key_ascii;
  logic       key_ready;
  logic       rd_req;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [7:0] ram_addr;
  logic [7:0] ram_data;
  logic       ram_wren;
  logic [7:0] ram_q;
  logic [3:0] cur_col;
  logic [3:0] cur_row;
  logic       busy;
  logic [7:0] drop_cnt;

  int checks   = 0;
  int failures = 0;
  int arb_viol = 0;

  logic [7:0] mem [256];
  logic [7:0] wq_addr [$];
  logic [7:0] wq_data [$];

  always #5 clk = ~clk;

  text_buffer_ctrl #(
    .COLS       (16),
    .ROWS       (12),
    .ADDR_W     (8),
    .FIFO_DEPTH (4),
    .BLANK_CHAR (8'h20)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .key_valid (key_valid),
    .key_ascii (key_ascii),
    .key_ready (key_ready),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .ram_wren  (ram_wren),
    .ram_q     (ram_q),
    .cur_col   (cur_col),
    .cur_row   (cur_row),
    .busy      (busy),
    .drop_cnt  (drop_cnt)
  );

  // Single-port RAM with registered read data.
  always @(posedge clk) begin
    ram_q <= mem[ram_addr];
    if (ram_wren) mem[ram_addr] <= ram_data;
  end

  // Write monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset && ram_wren) begin
      wq_addr.push_back(ram_addr);
      wq_data.push_back(ram_data);
      if (rd_req) arb_viol++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tickn(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_q();
    wq_addr.delete();
    wq_data.delete();
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    key_valid = 1'b0;
    rd_req    = 1'b0;
    tickn(2);
    reset = 1'b0;
    tick();
    clear_q();
  endtask

  task automatic send_key(input logic [7:0] b);
    int w = 0;
    while (!key_ready && w < 200) begin
      tick();
      w++;
    end
    if (!key_ready) check("key_ready_wait", key_ready, 1'b1);
    key_valid = 1'b1;
    key_ascii = b;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic wait_writes(input int n, input int budget);
    int w = 0;
    while (wq_addr.size() < n && w < budget) begin
      tick();
      w++;
    end
  endtask

  initial begin
    int errs;
    logic [7:0] k;
    reset     = 1'b1;
    key_valid = 1'b0;
    key_ascii = 8'h00;
    rd_req    = 1'b0;
    rd_addr   = 8'h00;
    tickn(2);

    // Reset state
    check("rst_key_ready", key_ready, 1'b0);
    check("rst_rd_valid",  rd_valid,  1'b0);
    check("rst_ram_wren",  ram_wren,  1'b0);
    check("rst_ram_addr",  ram_addr,  8'h00);
    check("rst_ram_data",  ram_data,  8'h00);
    check("rst_cur_col",   cur_col,   4'd0);
    check("rst_cur_row",   cur_row,   4'd0);
    check("rst_busy",      busy,      1'b0);
    check("rst_drop_cnt",  drop_cnt,  8'd0);
    reset = 1'b0;
    tick();
    check("key_ready_after_rst", key_ready, 1'b1);
    clear_q();

    // Single printable key
    send_key(8'h41);
    wait_writes(1, 3);
    check("a_wr_count", wq_addr.size(), 1);
    check("a_wr_addr", wq_addr[0], 8'h00);
    check("a_wr_data", wq_data[0], 8'h41);
    check("a_cur_col", cur_col, 4'd1);
    check("a_cur_row", cur_row, 4'd0);

    // 17 printables: row wrap into row 1
    do_reset();
    for (int i = 0; i < 17; i++) begin
      k = 8'h61 + 8'(i);
      send_key(k);
    end
    wait_writes(17, 200);
    check("p17_count", wq_addr.size(), 17);
    errs = 0;
    for (int i = 0; i < 17 && i < wq_addr.size(); i++) begin
      if (wq_addr[i] !== 8'(i) || wq_data[i] !== 8'h61 + 8'(i)) errs++;
    end
    check("p17_order_errs", errs, 0);
    check("p17_last_addr", wq_addr[16], 8'd16);
    check("p17_last_data", wq_data[16], 8'h71);
    check("p17_cur_col", cur_col, 4'd1);
    check("p17_cur_row", cur_row, 4'd1);

    // Last cell then wrap to (0,0)
    do_reset();
    for (int i = 0; i < 11; i++) send_key(8'h0D);
    tickn(3);
    check("cr11_cur_row", cur_row, 4'd11);
    check("cr11_cur_col", cur_col, 4'd0);
    for (int i = 0; i < 15; i++) send_key(8'h78);
    wait_writes(15, 200);
    check("x15_cur_col", cur_col, 4'd15);
    check("x15_cur_row", cur_row, 4'd11);
    clear_q();
    send_key(8'h5A);
    wait_writes(1, 10);
    check("last_count", wq_addr.size(), 1);
    check("last_addr", wq_addr[0], 8'd191);
    check("last_data", wq_data[0], 8'h5A);
    check("last_cur_col", cur_col, 4'd0);
    check("last_cur_row", cur_row, 4'd0);

    // VGA read priority
    do_reset();
    rd_addr = 8'd5;
    rd_req  = 1'b1;
    check("rd_valid_first", rd_valid, 1'b0);
    send_key(8'h42);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rd_valid_hold", rd_valid, 1'b1);
      check("rd_data_eq_q", rd_data, ram_q);
      check("rd_data_val", rd_data, 8'h66);
      check("rd_ram_addr", ram_addr, 8'd5);
      check("rd_no_wren", ram_wren, 1'b0);
    end
    check("rd_no_write", wq_addr.size(), 0);
    rd_req = 1'b0;
    tick();
    check("rd_release_count", wq_addr.size(), 1);
    check("rd_release_addr", wq_addr[0], 8'd0);
    check("rd_release_data", wq_data[0], 8'h42);

    // Screen clear with a key queued mid-clear
    do_reset();
    send_key(8'h1B);
    tick();
    check("clr_busy", busy, 1'b1);
    send_key(8'h4B);
    tickn(20);
    check("clr_busy_mid", busy, 1'b1);
    wait_writes(193, 500);
    check("clr_count", wq_addr.size(), 193);
    errs = 0;
    for (int i = 0; i < 192 && i < wq_addr.size(); i++) begin
      if (wq_addr[i] !== 8'(i) || wq_data[i] !== 8'h20) errs++;
    end
    check("clr_order_errs", errs, 0);
    check("clr_end_addr", wq_addr[191], 8'd191);
    check("clr_key_addr", wq_addr[192], 8'd0);
    check("clr_key_data", wq_data[192], 8'h4B);
    check("clr_busy_done", busy, 1'b0);
    check("clr_cur_col", cur_col, 4'd1);
    check("clr_cur_row", cur_row, 4'd0);

    // Full FIFO drops keys while writes are starved
    do_reset();
    rd_req = 1'b1;
    send_key(8'h43);
    tickn(2);
    for (int i = 0; i < 6; i++) begin
      key_valid = 1'b1;
      key_ascii = 8'h44 + 8'(i);
      tick();
    end
    key_valid = 1'b0;
    check("full_key_ready", key_ready, 1'b0);
    check("full_drop_cnt", drop_cnt, 8'd2);
    check("full_no_write", wq_addr.size(), 0);
    rd_req = 1'b0;
    wait_writes(5, 100);
    tickn(10);
    check("full_accepted", wq_addr.size(), 5);
    check("full_first_data", wq_data[0], 8'h43);
    check("full_last_data", wq_data[4], 8'h47);
    check("full_cur_col", cur_col, 4'd5);
    check("full_ready_again", key_ready, 1'b1);

    // Backspace, CR and ignored bytes
    do_reset();
    send_key(8'h0D);
    tickn(3);
    check("bs_pre_row", cur_row, 4'd1);
    clear_q();
    send_key(8'h08);
    tickn(4);
    check("bs_cur_col", cur_col, 4'd15);
    check("bs_cur_row", cur_row, 4'd0);
`ifdef TBC_ERASE_ON_BS_EN
    check("bs_erase_count", wq_addr.size(), 1);
    check("bs_erase_addr", wq_addr[0], 8'd15);
    check("bs_erase_data", wq_data[0], 8'h20);
`else
    check("bs_no_write", wq_addr.size(), 0);
`endif
    for (int i = 0; i < 3; i++) send_key(8'h0D);
    clear_q();
    for (int i = 0; i < 5; i++) send_key(8'h70);
    wait_writes(5, 50);
    check("cr_pre_col", cur_col, 4'd5);
    check("cr_pre_row", cur_row, 4'd3);
    send_key(8'h0D);
    tickn(3);
    check("cr_cur_col", cur_col, 4'd0);
    check("cr_cur_row", cur_row, 4'd4);
    for (int i = 0; i < 7; i++) send_key(8'h0D);
    tickn(3);
    check("cr_row11", cur_row, 4'd11);
    send_key(8'h0D);
    tickn(3);
    check("cr_wrap_row", cur_row, 4'd0);
    check("cr_wrap_col", cur_col, 4'd0);
    clear_q();
    send_key(8'h07);
    tickn(4);
    check("bel_col", cur_col, 4'd0);
    check("bel_row", cur_row, 4'd0);
    check("bel_no_write", wq_addr.size(), 0);
    check("bel_busy", busy, 1'b0);
    send_key(8'h08);
    tickn(4);
    check("bs00_col", cur_col, 4'd0);
    check("bs00_row", cur_row, 4'd0);
`ifdef TBC_ERASE_ON_BS_EN
    check("bs00_erase_count", wq_addr.size(), 1);
    check("bs00_erase_addr", wq_addr[0], 8'd0);
`else
    check("bs00_no_write", wq_addr.size(), 0);
`endif

    check("arb_violations", arb_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/text_buffer_ctrl.md
Name: text_buffer_ctrl

Overview:
- Sequencer and arbiter for the single-port character RAM that holds the 16x12 on-screen text grid, sized for 40x40-pixel cells on a 640x480 display.
- Accepts decoded ASCII bytes from the PS/2 keyboard path through a small FIFO and maintains the text cursor.
- Turns keystrokes into RAM writes, cursor moves or a full-screen clear.
- The VGA pattern generator reads the same RAM through this block and always has priority over writes.

Parameters:
- COLS, 16, characters per row
- ROWS, 12, rows per screen
- ADDR_W, 8, RAM address width; must satisfy 2^ADDR_W >= COLS*ROWS
- FIFO_DEPTH, 4, keystroke FIFO entries (power of 2)
- BLANK_CHAR, 8'h20, fill character for clear and erase

Ports:
- clk  in  1  system clock (CLOCK_50 domain); all inputs synchronous to it
- reset  in  1  synchronous, active-high reset
- key_valid  in  1  one-cycle strobe: key_ascii is valid
- key_ascii  in  8  ASCII byte from the keyboard decoder
- key_ready  out  1  FIFO not full
- rd_req  in  1  VGA read request, this cycle
- rd_addr  in  ADDR_W  VGA read address
- rd_data  out  8  read data; equals ram_q
- rd_valid  out  1  rd_data holds the result of the previous cycle's granted read
- ram_addr  out  ADDR_W  RAM address (combinational mux)
- ram_data  out  8  RAM write data
- ram_wren  out  1  RAM write enable
- ram_q  in  8  RAM registered output, 1-cycle latency
- cur_col  out  4  cursor column
- cur_row  out  4  cursor row
- busy  out  1  screen clear in progress
- drop_cnt  out  8  count of keystrokes dropped on a full FIFO; saturates at 255

Behaviour:
- Reset values:
  - outputs: key_ready=0, rd_valid=0, ram_wren=0, ram_addr=0, ram_data=0, cur_col=0, cur_row=0, busy=0, drop_cnt=0.
  - internal: FIFO empty, state=IDLE.
  - key_ready goes to 1 on the first cycle after reset deasserts.
  - Reset does not clear RAM contents.
  - Reset during CLEAR or WRITE aborts the operation immediately.
- FIFO:
  - Push when key_valid && key_ready.
  - key_valid while full: byte is dropped and drop_cnt increments (saturating).
  - key_ready is derived from the registered count; a push on a full cycle is rejected even if a pop occurs in the same cycle.
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
- Arbitration:
  - rd_req=1 always wins: ram_addr=rd_addr, ram_wren=0, rd_valid=1 on the next cycle.
  - Writes issue only on cycles with rd_req=0.
  - The VGA side must leave gaps (blanking) so writes are not starved.
- FSM states: IDLE, WRITE, CLEAR.
- IDLE with FIFO non-empty: pop the head and decode it.
  - Printable 0x20..0x7E: latch wr_addr=cur_row*COLS+cur_col and wr_data=byte; go to WRITE.
  - 0x0D (CR): cur_col=0; cur_row+1, wrapping ROWS-1 to 0. No write; stay in IDLE.
  - 0x08 (BS): if col>0, col-1; else if row>0, row-1 and col=COLS-1; else no move. No write; stay in IDLE.
  - 0x1B (ESC): clr_addr=0, busy=1, go to CLEAR.
  - Any other byte: discarded, no effect.
- WRITE: on the first cycle with rd_req=0:
  - ram_wren=1, ram_addr=wr_addr, ram_data=wr_data.
  - Cursor advances: col+1; at COLS-1 wrap to col 0, row+1; at row ROWS-1 wrap to row 0.
  - Return to IDLE.
- Throughput: at most one character per 2 cycles.
- CLEAR: on each cycle with rd_req=0, write BLANK_CHAR at clr_addr.
  - If clr_addr==COLS*ROWS-1: cursor=(0,0), busy=0, go to IDLE.
  - Otherwise clr_addr+1.
  - The FIFO keeps accepting keys during CLEAR but does not pop.
- Address arithmetic: row*COLS is a constant multiply, computed ADDR_W bits wide.

Optional Feature:
- Macro: TBC_ERASE_ON_BS_EN.
- Defined: BS moves the cursor as above, then enters WRITE with wr_addr=new cursor address and wr_data=BLANK_CHAR, with no cursor advance afterwards. BS at (0,0) blanks address 0.
- Undefined: BS moves the cursor only.

Decomposition:
- text_buffer_pkg holds:
  - ASCII constants: CR 8'h0D, BS 8'h08, ESC 8'h1B, printable range bounds.
  - FSM state encodings.
  - Default COLS and ROWS.
- One sub-module: tbc_key_fifo, a synchronous FIFO with full/empty flags and count, instanced once.
- Decode, cursor logic and arbitration stay in the top.

Test Plan:
- Reset, push 8'h41 with rd_req=0 -> ram_wren=1 with addr 0 and data 8'h41 within 3 cycles; cursor (1,0).
- Push 17 printables -> 17th written at addr 16, cursor (1,1); from cursor (15,11) a write lands at addr 191 and the cursor becomes (0,0).
- Hold rd_req=1 with rd_addr=5 while pushing 'B' -> no ram_wren, rd_valid=1 every cycle after the first, rd_data=ram_q; drop rd_req -> write issues on the next cycle.
- Push ESC -> busy=1, exactly 192 writes of 8'h20 to addr 0..191 in order, then busy=0 and cursor (0,0); a key pushed mid-clear is written at addr 0 afterwards.
- rd_req=1 continuously, push 6 keys -> 4 accepted, key_ready=0, drop_cnt=2.
- BS at (0,1) -> cursor (15,0), and with the macro defined addr 15 is written with 8'h20. CR at (5,3) -> (0,4). CR at row 11 -> row 0. Byte 8'h07 -> no change.
